// File: rtl/konami_pkg.sv
// Shared constants for the Konami-code sequence generator: switch image,
// direction encoding, playback table and FSM state type.
package konami_pkg;

    localparam logic [7:0] AB_CODE = 8'b10101011;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    localparam dir_t SEQ [0:7] = '{
        DIR_UP, DIR_UP, DIR_DOWN, DIR_DOWN,
        DIR_LEFT, DIR_RIGHT, DIR_LEFT, DIR_RIGHT
    };

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/konami_dir_decode.sv
// Maps a 2-bit direction plus enable to one-hot button bits {up, down, left, right}.
module konami_dir_decode
    import konami_pkg::*;
(
    input  dir_t       dir,
    input  logic       en,
    output logic [3:0] buttons
);

    always_comb begin
        buttons = 4'b0000;
        if (en) begin
            unique case (dir)
                DIR_UP:    buttons = 4'b1000;
                DIR_DOWN:  buttons = 4'b0100;
                DIR_LEFT:  buttons = 4'b0010;
                DIR_RIGHT: buttons = 4'b0001;
            endcase
        end
    end

endmodule

// File: rtl/konami_gen.sv
// Plays the Konami sequence onto sw/button outputs on a start request.
// Optional abort input is enabled by defining KONAMI_GEN_ABORT_EN.
module konami_gen
    import konami_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef KONAMI_GEN_ABORT_EN
    input  logic       abort,
`endif
    output logic [7:0] sw,
    output logic       button_up,
    output logic       button_down,
    output logic       button_left,
    output logic       button_right,
    output logic       busy,
    output logic       done
);

    // A zero-length phase is stretched to one cycle.
    localparam logic [15:0] SETUP_LOAD = 16'((SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1);
    localparam logic [15:0] PULSE_LOAD = 16'((PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD   = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  buttons_d;
    logic        abort_req;

`ifdef KONAMI_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    step_d  = 3'd0;
                    timer_d = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_q == 16'd0) begin
                    state_d = PULSE;
                    step_d  = 3'd0;
                    timer_d = PULSE_LOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            PULSE: begin
                if (timer_q == 16'd0) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            GAP: begin
                if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else if (step_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = PULSE;
                    step_d  = step_q + 3'd1;
                    timer_d = PULSE_LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = 3'd0;
                timer_d = 16'd0;
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
                timer_d = 16'd0;
            end
        endcase

        if (abort_req && (state_q inside {SETUP, PULSE, GAP})) begin
            state_d = IDLE;
            step_d  = 3'd0;
            timer_d = 16'd0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    konami_dir_decode u_dir_decode (
        .dir     (SEQ[step_d]),
        .en      (state_d == PULSE),
        .buttons (buttons_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= 3'd0;
            timer_q      <= 16'd0;
            sw           <= 8'h00;
            button_up    <= 1'b0;
            button_down  <= 1'b0;
            button_left  <= 1'b0;
            button_right <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            timer_q      <= timer_d;
            sw           <= (state_d != IDLE) ? AB_CODE : 8'h00;
            button_up    <= buttons_d[3];
            button_down  <= buttons_d[2];
            button_left  <= buttons_d[1];
            button_right <= buttons_d[0];
            busy         <= state_d inside {SETUP, PULSE, GAP};
            done         <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_konami_gen.sv
// Directed bench for konami_gen: default timing, ignored starts, mid-run reset
// and zero-length setup/gap parameters.
module tb_konami_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] sw0, sw1;
    logic       up0, dn0, lf0, rt0, busy0, done0;
    logic       up1, dn1, lf1, rt1, busy1, done1;
`ifdef KONAMI_GEN_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    konami_gen u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (start0),
`ifdef KONAMI_GEN_ABORT_EN
        .abort        (abort),
`endif
        .sw           (sw0),
        .button_up    (up0),
        .button_down  (dn0),
        .button_left  (lf0),
        .button_right (rt0),
        .busy         (busy0),
        .done         (done0)
    );

    konami_gen #(
        .SETUP_CYCLES (0),
        .PULSE_CYCLES (1),
        .GAP_CYCLES   (0)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start1),
`ifdef KONAMI_GEN_ABORT_EN
        .abort        (abort),
`endif
        .sw           (sw1),
        .button_up    (up1),
        .button_down  (dn1),
        .button_left  (lf1),
        .button_right (rt1),
        .busy         (busy1),
        .done         (done1)
    );

    // Hand-written button pattern per step, packed {up, down, left, right}.
    logic [3:0] exp_btn [0:7] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100,
                                  4'b0010, 4'b0001, 4'b0010, 4'b0001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] observe(input bit sel);
        if (sel) return {sw1, up1, dn1, lf1, rt1, busy1, done1};
        return {sw0, up0, dn0, lf0, rt0, busy0, done0};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Start in cycle 0, then check every output for cycles 1..last.
    // Pulses at first + i*per, done at done_cyc; stop_at > 0 ends the loop early.
    task automatic run_check(input bit sel, input int first, input int per, input int done_cyc,
                             input int last, input bit extra, input int stop_at);
        logic [3:0]  btn;
        logic [13:0] exp;
        @(posedge clk);
        #1 set_start(sel, 1'b1);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            btn = 4'b0000;
            if (k >= first && (k - first) % per == 0 && (k - first) / per < 8)
                btn = exp_btn[(k - first) / per];
            exp = {(k <= done_cyc) ? 8'hAB : 8'h00, btn,
                   (k < done_cyc) ? 1'b1 : 1'b0, (k == done_cyc) ? 1'b1 : 1'b0};
            check($sformatf("dut%0d_c%0d", sel, k), 32'(observe(sel)), 32'(exp));
            set_start(sel, extra && (k == 10 || k == 35));
            if (stop_at > 0 && k == stop_at) break;
        end
        set_start(sel, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'(observe(1'b0)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", 32'(observe(1'b0)), 32'd0);

        // Default timing: pulses 3,7..31, done at 35.
        run_check(1'b0, 3, 4, 35, 40, 1'b0, 0);

        // Starts at cycles 10 and 35 must be ignored: single run, single done.
        run_check(1'b0, 3, 4, 35, 50, 1'b1, 0);

        // Reset mid-run at cycle 20 clears everything at once.
        run_check(1'b0, 3, 4, 35, 40, 1'b0, 20);
        reset = 1'b1;
        #1;
        check("mid_reset", 32'(observe(1'b0)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(observe(1'b0)), 32'd0);
        run_check(1'b0, 3, 4, 35, 38, 1'b0, 0);

        // SETUP_CYCLES=0, GAP_CYCLES=0 behave as 1: pulses 2,4..16, done at 18.
        run_check(1'b1, 2, 2, 18, 22, 1'b0, 0);
        check("dut0_idle_end", 32'(observe(1'b0)), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
